// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle press/release/long-press/repeat events.
// Auto-repeat is built only with BTN_AUTO_REPEAT_EN; `release`/`repeat` are reserved words,
// so those pulses are named release_pulse/repeat_pulse.
module button_event_decoder #(
    parameter int unsigned TIMER_WIDTH   = 26,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic       press,
    output logic       release_pulse,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        StWaitRel,
        StIdle,
        StPressed,
        StLong
    } state_e;

    localparam logic [TIMER_WIDTH-1:0] HoldLast = TIMER_WIDTH'(HOLD_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   long_q, long_d;
    logic                   held_q, held_d;
    logic [7:0]             count_q, count_d;

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [TIMER_WIDTH-1:0] RepeatLast = TIMER_WIDTH'(REPEAT_CYCLES - 1);
    logic repeat_q, repeat_d;
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        count_d   = count_q;
`ifdef BTN_AUTO_REPEAT_EN
        repeat_d  = 1'b0;
`endif
        unique case (state_q)
            // A level already high at reset must drop before any press is reported.
            StWaitRel: begin
                if (!in) state_d = StIdle;
            end
            StIdle: begin
                if (in) begin
                    state_d = StPressed;
                    timer_d = '0;
                    press_d = 1'b1;
                    count_d = count_q + 8'd1;
                end
            end
            StPressed: begin
                if (!in) begin
                    state_d   = StIdle;
                    release_d = 1'b1;
                    timer_d   = '0;
                end else if (timer_q == HoldLast) begin
                    state_d = StLong;
                    long_d  = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_WIDTH'(1);
                end
            end
            StLong: begin
                if (!in) begin
                    state_d   = StIdle;
                    release_d = 1'b1;
                    timer_d   = '0;
                end else begin
`ifdef BTN_AUTO_REPEAT_EN
                    if (timer_q == RepeatLast) begin
                        repeat_d = 1'b1;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + TIMER_WIDTH'(1);
                    end
`endif
                end
            end
            default: state_d = StWaitRel;
        endcase
        held_d = (state_d == StPressed) || (state_d == StLong);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StWaitRel;
            timer_q   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            held_q    <= held_d;
            count_q   <= count_d;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end
    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign press         = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign held          = held_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: the driver queues expected events with their
// cycle of appearance, a negedge monitor pops and compares every pulse the DUT emits.
module tb_button_event_decoder;

    localparam int HOLD = 8;
    localparam int REP  = 4;

    localparam int EvPress   = 0;
    localparam int EvRelease = 1;
    localparam int EvLong    = 2;
    localparam int EvRepeat  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       in;
    logic       press;
    logic       release_pulse;
    logic       long_press;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] press_count;

    button_event_decoder #(
        .TIMER_WIDTH  (4),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in           (in),
        .press        (press),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int at;
        int cnt;
    } ev_t;

    ev_t exp_q[$];
    int  checks    = 0;
    int  failures  = 0;
    int  exp_count = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input int at, input int cnt);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every pulse must match the head of the expected-event queue.
    int  mon_n;
    int  mon_kind;
    ev_t mon_ev;
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            mon_n = int'(press) + int'(release_pulse) + int'(long_press) + int'(repeat_pulse);
            if (mon_n > 1) begin
                check("pulse_overlap", mon_n, 1);
            end else if (mon_n == 1) begin
                mon_kind = press ? EvPress : release_pulse ? EvRelease
                         : long_press ? EvLong : EvRepeat;
                if (exp_q.size() == 0) begin
                    check("unexpected_event_kind", mon_kind, -1);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check("event_kind", mon_kind, mon_ev.kind);
                    check("event_cycle", cyc, mon_ev.at);
                    if (mon_kind == EvPress) check("press_count_on_press", int'(press_count),
                                                   mon_ev.cnt);
                end
            end
        end
    end

    // From IDLE: drive in=1 for n sampled edges, then low for one edge.
    task automatic hold(input int n);
        int c;
        c = cyc;
        in = 1'b1;
        exp_count = (exp_count + 1) % 256;
        push(EvPress, c + 1, exp_count);
        if (n >= HOLD + 1) push(EvLong, c + HOLD + 1, 0);
`ifdef BTN_AUTO_REPEAT_EN
        for (int k = 1; HOLD + 1 + REP * k <= n; k++) push(EvRepeat, c + HOLD + 1 + REP * k, 0);
`endif
        push(EvRelease, c + n + 1, 0);
        for (int k = 1; k <= n; k++) begin
            step();
            check("held_high", int'(held), 1);
        end
        in = 1'b0;
        step();
        check("held_low", int'(held), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_press"}, int'(press), 0);
        check({tag, "_release"}, int'(release_pulse), 0);
        check({tag, "_long"}, int'(long_press), 0);
        check({tag, "_repeat"}, int'(repeat_pulse), 0);
        check({tag, "_held"}, int'(held), 0);
        check({tag, "_count"}, int'(press_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        reset = 1'b0;
        in    = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("reset");
        step();
        step();
        reset = 1'b0;
        step();

        // Short press: 3 cycles high.
        hold(3);
        check("count_after_short", int'(press_count), 1);
        step();

        // Long hold: long_press and (when built in) repeats.
        hold(21);
        step();

        // Fall exactly when timer reaches HOLD-1: release wins, no long_press.
        hold(8);
        step();

        // Reset in the middle of LONG with the button still down.
        c  = cyc;
        in = 1'b1;
        exp_count = (exp_count + 1) % 256;
        push(EvPress, c + 1, exp_count);
        push(EvLong, c + HOLD + 1, 0);
        repeat (10) step();
        check("held_in_long", int'(held), 1);
        #2 reset = 1'b1;
        #1 check_all_zero("midlong_reset");
        exp_count = 0;
        repeat (3) step();
        reset = 1'b0;
        repeat (4) step();
        check("no_press_after_reset_count", int'(press_count), 0);
        check("no_held_after_reset", int'(held), 0);
        in = 1'b0;
        step();
        hold(3);
        check("count_after_reset_press", int'(press_count), 1);
        step();

        // 257 one-cycle presses from a fresh reset: counter wraps to 1.
        #2 reset = 1'b1;
        exp_count = 0;
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 257; i++) hold(1);
        check("count_wrap", int'(press_count), 1);
        repeat (3) step();
        check("pending_events", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
